int_iq_slot_ctrl: RTL



---
 rtl/int_iq_slot_ctrl_pkg.sv | 23 ++
 rtl/int_iq_free_ring.sv | 58 +++++
 rtl/int_iq_slot_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/int_iq_slot_ctrl_pkg.sv
// Shared parameters, state encoding and tag helpers for the integer issue-queue slot allocator.
package int_iq_slot_ctrl_pkg;

  localparam int SLOTNUM    = 8;
  localparam int SLOTW      = 5;
  localparam int SLOTSTRIDE = 4;
  localparam int SLOTSHIFT  = $clog2(SLOTSTRIDE);
  localparam int IDXW       = $clog2(SLOTNUM);
  localparam int CNTW       = 4;
  localparam int TAGLIM     = SLOTNUM * SLOTSTRIDE;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [IDXW-1:0] tag2idx(input logic [SLOTW-1:0] tag);
    logic [SLOTW-1:0] w_sh;
    w_sh = tag >> SLOTSHIFT;
    return w_sh[IDXW-1:0];
  endfunction

endpackage

// File: rtl/int_iq_free_ring.sv
// Circular free list of slot tags: push at tail, combinational head read, occupancy count.
import int_iq_slot_ctrl_pkg::*;

module int_iq_free_ring (
  input  logic              i_clk,
  input  logic              i_rest,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [SLOTW-1:0]  i_push_tag,
  input  logic              i_pop,
  output logic [SLOTW-1:0]  o_head_tag,
  output logic [CNTW-1:0]   o_count
);

  logic [SLOTW-1:0] r_mem [SLOTNUM];
  logic [IDXW-1:0]  r_head;
  logic [IDXW-1:0]  r_tail;
  logic [CNTW-1:0]  r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_pop_ok   = i_pop && (r_count != {CNTW{1'b0}});
  // A full ring only accepts a push when a pop frees an entry in the same cycle.
  assign w_push_ok  = i_push && ((r_count != CNTW'(SLOTNUM)) || w_pop_ok);
  assign o_head_tag = r_mem[r_head];
  assign o_count    = r_count;

  // Tag storage, written at the tail.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      for (int i = 0; i < SLOTNUM; i++) begin
        r_mem[i] <= {SLOTW{1'b0}};
      end
    end else if (w_push_ok) begin
      r_mem[r_tail] <= i_push_tag;
    end else begin
      r_mem[r_tail] <= r_mem[r_tail];
    end
  end

  // Head, tail and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rest || i_clear) begin
      r_head  <= {IDXW{1'b0}};
      r_tail  <= {IDXW{1'b0}};
      r_count <= {CNTW{1'b0}};
    end else begin
      r_head <= w_pop_ok  ? r_head + IDXW'(1) : r_head;
      r_tail <= w_push_ok ? r_tail + IDXW'(1) : r_tail;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/int_iq_slot_ctrl.sv
// Issue-queue slot allocator: refill sequencing, dispatch grant, issue release, busy bitmap.
// Optional free-tag legality checking is enabled by defining IQ_SLOT_CHECK_EN.
import int_iq_slot_ctrl_pkg::*;

module int_iq_slot_ctrl (
  input  logic               i_clk,
  input  logic               i_rest,
  input  logic               i_disp_valid,
  output logic               o_disp_ready,
  output logic [SLOTW-1:0]   o_disp_tag,
  input  logic               i_issue_valid,
  input  logic [SLOTW-1:0]   i_issue_tag,
  input  logic               i_flush,
  output logic [CNTW-1:0]    o_free_count,
  output logic [SLOTNUM-1:0] o_slot_busy,
  output logic               o_init_done,
  output logic               o_err_free
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDXW-1:0]    r_fill;
  logic [IDXW-1:0]    w_fill_nxt;
  logic [SLOTNUM-1:0] r_busy;
  logic [SLOTNUM-1:0] w_busy_nxt;
  logic [SLOTNUM-1:0] w_set_mask;
  logic [SLOTNUM-1:0] w_clr_mask;
  logic               w_run;
  logic               w_hs;
  logic               w_issue_run;
  logic               w_issue_ok;
  logic               w_push;
  logic [SLOTW-1:0]   w_push_tag;
  logic [SLOTW-1:0]   w_head_tag;
  logic [CNTW-1:0]    w_count;

  assign w_run        = (r_state == ST_RUN);
  assign o_disp_ready = w_run && (w_count != {CNTW{1'b0}});
  assign o_disp_tag   = w_head_tag;
  assign o_free_count = w_count;
  assign o_slot_busy  = r_busy;
  assign o_init_done  = w_run;
  assign w_hs         = i_disp_valid && o_disp_ready && !i_flush;
  assign w_issue_run  = i_issue_valid && w_run && !i_flush;

`ifdef IQ_SLOT_CHECK_EN
  logic [SLOTW:0] w_tag_ext;
  logic           w_tag_legal;
  logic           r_err_free;

  assign w_tag_ext   = {1'b0, i_issue_tag};
  assign w_tag_legal = (i_issue_tag[SLOTSHIFT-1:0] == {SLOTSHIFT{1'b0}})
                    && (w_tag_ext < (SLOTW+1)'(TAGLIM))
                    && r_busy[tag2idx(i_issue_tag)];
  assign w_issue_ok  = w_issue_run && w_tag_legal;
  assign o_err_free  = r_err_free;

  // Sticky illegal-free flag, cleared only by reset or flush.
  always_ff @(posedge i_clk) begin
    if (i_rest || i_flush) begin
      r_err_free <= 1'b0;
    end else if (w_issue_run && !w_tag_legal) begin
      r_err_free <= 1'b1;
    end else begin
      r_err_free <= r_err_free;
    end
  end
`else
  assign w_issue_ok = w_issue_run;
  assign o_err_free = 1'b0;
`endif

  // The refill sequence shares the ring's push port with issue releases.
  always_comb begin
    w_push     = 1'b0;
    w_push_tag = i_issue_tag;
    if (r_state == ST_INIT) begin
      w_push     = !i_flush;
      w_push_tag = SLOTW'(r_fill) << SLOTSHIFT;
    end else begin
      w_push     = w_issue_ok;
      w_push_tag = i_issue_tag;
    end
  end

  // State and fill counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      r_state <= ST_INIT;
      r_fill  <= {IDXW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
    end
  end

  // Next-state logic; flush restarts the refill from slot 0.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    if (i_flush) begin
      w_state_nxt = ST_INIT;
      w_fill_nxt  = {IDXW{1'b0}};
    end else begin
      case (r_state)
        ST_INIT: begin
          w_fill_nxt = r_fill + IDXW'(1);
          if (r_fill == IDXW'(SLOTNUM - 1)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_INIT;
          end
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
          w_fill_nxt  = r_fill;
        end
        default: begin
          w_state_nxt = ST_INIT;
          w_fill_nxt  = {IDXW{1'b0}};
        end
      endcase
    end
  end

  assign w_set_mask = w_hs       ? (SLOTNUM'(1) << tag2idx(w_head_tag))  : {SLOTNUM{1'b0}};
  assign w_clr_mask = w_issue_ok ? (SLOTNUM'(1) << tag2idx(i_issue_tag)) : {SLOTNUM{1'b0}};
  assign w_busy_nxt = i_flush ? {SLOTNUM{1'b0}} : ((r_busy | w_set_mask) & ~w_clr_mask);

  // Busy bitmap register.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      r_busy <= {SLOTNUM{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  int_iq_free_ring u_ring (
    .i_clk      (i_clk),
    .i_rest     (i_rest),
    .i_clear    (i_flush),
    .i_push     (w_push),
    .i_push_tag (w_push_tag),
    .i_pop      (w_hs),
    .o_head_tag (w_head_tag),
    .o_count    (w_count)
  );

endmodule
